image_writer: RTL and testbench



---
 rtl/image_writer.sv | 99 +++++++++
 tb/tb_image_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/image_writer.sv
// image_writer: command sequencer driving the 1-bit frame buffer write port (clear / 8x8 glyph draw).
// Define IMAGE_WRITER_TRANSPARENT_EN to make DRAW write only foreground (1) pixels.
module image_writer #(
  parameter int   ROWS      = 64,
  parameter int   COLS      = 128,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_char,
  input  logic [6:0]  cmd_row,
  input  logic [6:0]  cmd_col,
  output logic        busy,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        we,
  output logic [6:0]  rowW,
  output logic [6:0]  colW,
  output logic        dataW
);
  typedef enum logic [2:0] {IDLE, CLR, ADDR, LOAD, WRITE} state_t;
  state_t state, state_n;
  logic [7:0] chr, shift;
  logic [6:0] base_row, base_col, r, c;
  logic [2:0] line, pix;
  logic [7:0] row_sum, col_sum;
  logic       in_bounds, clr_last, wr_en;
  // 8-bit sums so a glyph hanging off the bottom/right edge is clipped, never wrapped
  assign row_sum   = {1'b0, base_row} + {5'b0, line};
  assign col_sum   = {1'b0, base_col} + {5'b0, pix};
  assign in_bounds = (row_sum < 8'(ROWS)) && (col_sum < 8'(COLS));
  assign clr_last  = (r == 7'(ROWS - 1)) && (c == 7'(COLS - 1));
`ifdef IMAGE_WRITER_TRANSPARENT_EN
  assign wr_en = in_bounds && shift[7];
`else
  assign wr_en = in_bounds;
`endif
  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = state != IDLE;
  assign font_addr = {chr, line};
  assign we        = (state == CLR) || ((state == WRITE) && wr_en);
  assign rowW      = state == CLR ? r : state == WRITE ? row_sum[6:0] : '0;
  assign colW      = state == CLR ? c : state == WRITE ? col_sum[6:0] : '0;
  assign dataW     = state == CLR ? CLEAR_VAL : (state == WRITE) && shift[7];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = cmd_op ? CLR : ADDR;
      CLR:     if (clr_last) state_n = IDLE;
      ADDR:    state_n = LOAD;
      LOAD:    state_n = WRITE;
      WRITE:   if (pix == 3'd7) state_n = line == 3'd7 ? IDLE : ADDR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      chr      <= '0;
      shift    <= '0;
      base_row <= '0;
      base_col <= '0;
      r        <= '0;
      c        <= '0;
      line     <= '0;
      pix      <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (cmd_valid) begin
          chr      <= cmd_char;
          base_row <= cmd_row;
          base_col <= cmd_col;
          line     <= '0;
          pix      <= '0;
          r        <= '0;
          c        <= '0;
        end
        CLR: begin
          c <= c == 7'(COLS - 1) ? '0 : c + 7'd1;
          if (c == 7'(COLS - 1)) r <= r + 7'd1;
        end
        LOAD: begin
          shift <= font_data;
          pix   <= '0;
        end
        WRITE: begin
          shift <= {shift[6:0], 1'b0};
          pix   <= pix + 3'd1;
          if (pix == 3'd7) line <= line + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_image_writer.sv
// tb_image_writer: scoreboard bench; stimulus pushes expected writes, monitors pop and compare.
module tb_image_writer;
`ifdef IMAGE_WRITER_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_op = 0, cmd_ready, busy, we, dataW;
  logic [7:0] cmd_char = 0, font_data = 0;
  logic [6:0] cmd_row = 0, cmd_col = 0, rowW, colW;
  logic [10:0] font_addr;
  logic s_valid = 0, s_ready, s_busy, s_we, s_data;
  logic [6:0] s_row, s_col;
  logic [10:0] s_fa;
  logic [7:0] rom [8];
  int total = 0, bad = 0, nw = 0;
  int q[$], sq[$];

  always #5 clk = ~clk;

  image_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_char(cmd_char), .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy),
    .font_addr(font_addr), .font_data(font_data), .we(we), .rowW(rowW), .colW(colW), .dataW(dataW)
  );

  image_writer #(.ROWS(4), .COLS(8), .CLEAR_VAL(1'b0)) dut_s (
    .clk(clk), .rst(rst), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(1'b1),
    .cmd_char(8'h00), .cmd_row(7'd0), .cmd_col(7'd0), .busy(s_busy),
    .font_addr(s_fa), .font_data(8'h00), .we(s_we), .rowW(s_row), .colW(s_col), .dataW(s_data)
  );

  always @(posedge clk) font_data <= rom[font_addr[2:0]];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) if (we) begin
    nw++;
    if (q.size() == 0) chk("unexpected_write", {rowW, colW, dataW}, -1);
    else chk("write", {rowW, colW, dataW}, q.pop_front());
  end

  always @(negedge clk) if (s_we) begin
    if (sq.size() == 0) chk("small_unexpected_write", {s_row, s_col, s_data}, -1);
    else chk("small_write", {s_row, s_col, s_data}, sq.pop_front());
  end

  function automatic int enc(input int r, input int c, input int d);
    return (r << 8) | (c << 1) | d;
  endfunction

  task automatic exp_draw(input int row, input int col);
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 8; b++) begin
        int r = row + l, c = col + b, d = int'(rom[l][7-b]);
        if (r < 64 && c < 128 && (!TR || d == 1)) q.push_back(enc(r, c, d));
      end
  endtask

  task automatic set_rom(input logic [7:0] l0, input logic [7:0] rest);
    rom[0] = l0;
    for (int i = 1; i < 8; i++) rom[i] = rest;
  endtask

  task automatic run_busy(input int exp, input string nm, input bit cfa, input int fa);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > exp + 20) break;
      if (n == 0 && cfa) chk({nm, "_font_addr"}, int'(font_addr), fa);
      n++;
    end
    chk({nm, "_busy_cycles"}, n, exp);
    chk({nm, "_ready_after"}, int'(cmd_ready), 1);
  endtask

  task automatic issue(input bit op, input int ch, input int row, input int col, input string nm);
    cmd_op = op; cmd_char = 8'(ch); cmd_row = 7'(row); cmd_col = 7'(col); cmd_valid = 1;
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
    chk({nm, "_accept"}, int'(cmd_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w0;
    set_rom(8'h00, 8'h00);
    repeat (2) begin
      @(negedge clk);
      chk("rst_we", int'(we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_outs", int'({rowW, colW, dataW, font_addr}), 0);

    // clear on the 4x8 instance
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) sq.push_back(enc(r, c, 0));
    @(posedge clk); #1 s_valid = 1;
    @(posedge clk); #1 s_valid = 0;
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (!s_busy || n > 60) break;
        chk("small_clear_we_every_cycle", int'(s_we), 1);
        n++;
      end
      chk("small_clear_busy_cycles", n, 32);
      chk("small_clear_ready_after", int'(s_ready), 1);
      chk("small_clear_drained", sq.size(), 0);
    end

    // draw 0x41 at (0,37)
    set_rom(8'hA5, 8'h00);
    exp_draw(0, 37);
    w0 = nw;
    issue(0, 8'h41, 0, 37, "draw");
    cmd_valid = 0;
    run_busy(80, "draw", 1, 11'h208);
    chk("draw_writes", nw - w0, TR ? 4 : 64);

    // reset for 2 cycles while idle
    @(posedge clk); #1 rst = 1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_rst_we", int'(we), 0);
      chk("idle_rst_ready", int'(cmd_ready), 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_rst_ready_after", int'(cmd_ready), 1);
    chk("idle_rst_font_addr", int'(font_addr), 0);

    // clipped draw at the bottom-right corner
    set_rom(8'hFF, 8'hFF);
    exp_draw(62, 124);
    w0 = nw;
    issue(0, 8'h7F, 62, 124, "clip");
    cmd_valid = 0;
    run_busy(80, "clip", 1, 11'h3F8);
    chk("clip_writes", nw - w0, 8);

    // reset in cycle 20 of a draw: lines 0 and 1 written, nothing after
    for (int l = 0; l < 2; l++) for (int b = 0; b < 8; b++) q.push_back(enc(l, b, 1));
    issue(0, 8'h01, 0, 0, "abort");
    cmd_valid = 0;
    repeat (19) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_we", int'(we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    repeat (100) @(negedge clk);
    chk("abort_drained", q.size(), 0);

    // back-to-back: clear then draw with cmd_valid held
    set_rom(8'hA5, 8'h00);
    for (int r = 0; r < 64; r++) for (int c = 0; c < 128; c++) q.push_back(enc(r, c, 0));
    exp_draw(10, 20);
    issue(1, 0, 0, 0, "b2b_clear");
    cmd_op = 0; cmd_char = 8'h42; cmd_row = 7'd10; cmd_col = 7'd20;
    run_busy(8192, "b2b_clear", 0, 0);
    @(posedge clk); #1 cmd_valid = 0;
    w0 = nw;
    run_busy(80, "b2b_draw", 1, 11'h210);
    chk("b2b_draw_writes", nw - w0, TR ? 4 : 64);
    repeat (5) @(negedge clk);
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
